// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU vs load unit) with register busy scoreboard.
// Grants are combinational; the chosen write is registered with 1-cycle latency, and the loser keeps its request held.
module regfile_wb_arbiter #(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  input  logic        rsv_EN,
  input  logic [4:0]  rsv_address,
  input  logic [4:0]  query_address1,
  input  logic [4:0]  query_address2,
  output logic        busy1,
  output logic        busy2,
  output logic        write_EN,
  output logic [4:0]  write_address,
  output logic [31:0] write_data
);

  // ptr_q = 0 favours ALU on contention, 1 favours MEM
  logic        ptr_q, ptr_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;
  logic        grant_alu, grant_mem;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        grant_alu = ~ptr_q;
        grant_mem = ptr_q;
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_comb begin
    ptr_d = ptr_q;
    if (alu_valid && mem_valid) begin
      ptr_d = ~ptr_q;
    end
  end

  always_comb begin
    sel_addr = grant_mem ? mem_addr : alu_addr;
    sel_data = grant_mem ? mem_data : alu_data;
    // Writes to x0 are accepted but never reach the register file
    wen_d    = (grant_alu || grant_mem) && (sel_addr != 5'd0);
    waddr_d  = wen_d ? sel_addr : waddr_q;
    wdata_d  = wen_d ? sel_data : wdata_q;
  end

  // Clear first so a same-edge reserve of the written register wins
  always_comb begin
    busy_d = busy_q;
    if (wen_d) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (rsv_EN) begin
      busy_d[rsv_address] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= PRIO_INIT;
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign write_EN      = wen_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign busy1         = busy_q[query_address1];
  assign busy2         = busy_q[query_address2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural arbiter/scoreboard model.
module tb_regfile_wb_arbiter;

  localparam logic PRIO = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        rsv_EN;
  logic [4:0]  rsv_address, query_address1, query_address2;
  logic        busy1, busy2, write_EN;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: pending-write bits, favoured requester (0 ALU, 1 MEM), last written address/data
  bit          m_busy[32];
  int          m_fav;
  logic [4:0]  m_la;
  logic [31:0] m_ld;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.PRIO_INIT(PRIO)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rsv_EN(rsv_EN), .rsv_address(rsv_address),
    .query_address1(query_address1), .query_address2(query_address2),
    .busy1(busy1), .busy2(busy2),
    .write_EN(write_EN), .write_address(write_address), .write_data(write_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_fav = int'(PRIO);
    m_la  = 5'd0;
    m_ld  = 32'd0;
  endtask

  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic rv, input logic [4:0] ra,
                      input logic [4:0] q1, input logic [4:0] q2, output int who);
    logic [4:0] addr;
    logic       en;
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    rsv_EN = rv; rsv_address = ra;
    query_address1 = q1; query_address2 = q2;
    #1;
    who = -1;
    if (av && mv) begin
      who   = m_fav;
      m_fav = 1 - m_fav;
    end else if (av) begin
      who = 0;
    end else if (mv) begin
      who = 1;
    end
    check("alu_ready", alu_ready, who == 0);
    check("mem_ready", mem_ready, who == 1);
    check("one_ready", alu_ready & mem_ready, 0);
    check("busy1", busy1, m_busy[q1]);
    check("busy2", busy2, m_busy[q2]);
    en = 1'b0;
    if (who >= 0) begin
      addr = (who == 1) ? ma : aa;
      if (addr != 5'd0) begin
        en           = 1'b1;
        m_la         = addr;
        m_ld         = (who == 1) ? md : ad;
        m_busy[addr] = 1'b0;
      end
    end
    if (rv && ra != 5'd0) m_busy[ra] = 1'b1;
    @(posedge clk);
    #1;
    check("write_EN", write_EN, en);
    check("write_address", write_address, m_la);
    check("write_data", write_data, m_ld);
  endtask

  initial begin
    int          who;
    logic        av, mv;
    logic [4:0]  aa, ma;
    logic [31:0] ad, md;

    reset = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h1234;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h5678;
    rsv_EN = 1'b1; rsv_address = 5'd2;
    query_address1 = 5'd2; query_address2 = 5'd4;
    model_reset();
    #12;
    check("rst_write_EN", write_EN, 0);
    check("rst_write_address", write_address, 0);
    check("rst_write_data", write_data, 0);
    check("rst_busy1", busy1, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; rsv_EN = 1'b0;

    // Lone ALU write, then idle
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, who);

    // Contention for four cycles: alternating grants
    for (int i = 0; i < 4; i++)
      step(1, 5'(10 + i), 32'hA000_0000 + i, 1, 5'(20 + i), 32'hB000_0000 + i,
           0, 5'd0, 5'd0, 5'd0, who);

    // x0 writes and reservations are dropped
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, who);

    // Scoreboard set, clear, and same-edge set-wins on register 7
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0, who);
    step(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0, who);
    step(1, 5'd7, 32'h78, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0, who);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0, who);

    // Random traffic; each requester holds its request until accepted
    av = 1'b0; mv = 1'b0; aa = 5'd0; ma = 5'd0; ad = 32'd0; md = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if (!av) begin
        av = ($urandom_range(0, 2) != 0);
        aa = 5'($urandom_range(0, 9));
        ad = $urandom;
      end
      if (!mv) begin
        mv = ($urandom_range(0, 2) != 0);
        ma = 5'($urandom_range(0, 9));
        md = $urandom;
      end
      step(av, aa, ad, mv, ma, md, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 9)),
           5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), who);
      if (who == 0) av = 1'b0;
      if (who == 1) mv = 1'b0;
    end

    // Asynchronous reset while a write is on the outputs and register 3 is busy
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd3, who);
    step(1, 5'd9, 32'hCAFE_F00D, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd3, who);
    #1;
    check("pre_rst_busy2", busy2, m_busy[3]);
    alu_valid = 1'b1; alu_addr = 5'd11; mem_valid = 1'b1; mem_addr = 5'd12;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_write_EN", write_EN, 0);
    check("arst_write_address", write_address, 0);
    check("arst_write_data", write_data, 0);
    check("arst_busy2", busy2, 0);
    check("arst_alu_ready", alu_ready, 0);
    check("arst_mem_ready", mem_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd3, who);
    for (int i = 0; i < 2; i++)
      step(1, 5'd13, 32'h1300 + i, 1, 5'd14, 32'h1400 + i, 0, 5'd0, 5'd13, 5'd14, who);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
